prio_enc_148: RTL and testbench

PRIO_ENC_148 -- requirements
Module: prio_enc_148

---
 rtl/prio_enc_pkg.sv | 17 +
 rtl/req_debounce.sv | 26 ++
 rtl/prio_enc_148.sv | 82 ++++++++
 tb/tb_prio_enc_148.sv | 134 +++++++++++++
 4 files changed

// File: rtl/prio_enc_pkg.sv
// prio_enc_pkg: shared types, constants and helpers for the 8-to-3 priority encoder.
package prio_enc_pkg;
    typedef enum logic [1:0] {IDLE, HOLD, RELEASE} state_t;
    typedef logic [2:0] idx_t;
    localparam idx_t CODE_IDLE_N = 3'b111;
    // Highest set bit wins; bit 7 has top priority.
    function automatic idx_t prio_idx(input logic [7:0] act);
        idx_t r = '0;
        for (int i = 0; i < 8; i++)
            if (act[i]) r = idx_t'(i);
        return r;
    endfunction
    // Lines strictly above idx in priority.
    function automatic logic [7:0] above_mask(input idx_t idx);
        return 8'hFE << idx;
    endfunction
endpackage

// File: rtl/req_debounce.sv
// req_debounce: single-line filter; output follows input after DEBOUNCE_CYCLES identical samples.
module req_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_din,
    output logic o_dout
);
    logic       r_dout;
    logic [3:0] r_cnt;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout <= 1'b1;
            r_cnt  <= '0;
        end else if (i_din == r_dout) begin
            r_cnt  <= '0;
        end else if (r_cnt == 4'(DEBOUNCE_CYCLES - 1)) begin
            r_dout <= i_din;
            r_cnt  <= '0;
        end else begin
            r_cnt  <= r_cnt + 4'd1;
        end
    end
    assign o_dout = r_dout;
endmodule

// File: rtl/prio_enc_148.sv
// prio_enc_148: registered 74LS148-style priority encoder with capture/ack handshake.
// Optional per-line debounce filtering is built when PRIO_ENC_DEBOUNCE_EN is defined.
module prio_enc_148
    import prio_enc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ei_n,
    input  logic [7:0] req_n,
    input  logic       ack,
    output logic [2:0] code_n,
    output logic       valid,
    output logic       gs_n,
    output logic       eo_n
);
    logic [7:0] r_req_q;
    logic       r_ei_q;
    logic [7:0] w_req_f;
    logic [7:0] w_act;
    logic       w_any;
    state_t     r_state;
    state_t     w_next;
    idx_t       r_held_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_q <= 8'hFF;
            r_ei_q  <= 1'b1;
        end else begin
            r_req_q <= req_n;
            r_ei_q  <= ei_n;
        end
    end

`ifdef PRIO_ENC_DEBOUNCE_EN
    for (genvar g = 0; g < 8; g++) begin : g_deb
        req_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clk   (clk),
            .rst   (rst),
            .i_din (r_req_q[g]),
            .o_dout(w_req_f[g])
        );
    end
`else
    logic w_unused_cfg;
    assign w_unused_cfg = ^DEBOUNCE_CYCLES;
    assign w_req_f = r_req_q;
`endif

    assign w_act = ~w_req_f;
    assign w_any = |w_act;
    assign gs_n  = r_ei_q | ~w_any;
    assign eo_n  = r_ei_q | w_any;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_held_idx <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_next == HOLD) r_held_idx <= prio_idx(w_act);
        end
    end

    // RELEASE waits until the held line drops or something more urgent appears.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = (!r_ei_q && w_any) ? HOLD : IDLE;
            HOLD:    w_next = ack ? RELEASE : HOLD;
            RELEASE: w_next = (!w_act[r_held_idx] || |(w_act & above_mask(r_held_idx))) ? IDLE : RELEASE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        valid  = r_state == HOLD;
        code_n = valid ? ~r_held_idx : CODE_IDLE_N;
    end
endmodule

// File: tb/tb_prio_enc_148.sv
// tb_prio_enc_148: directed self-checking bench for prio_enc_148 (debounce path when PRIO_ENC_DEBOUNCE_EN).
module tb_prio_enc_148;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ei_n = 1'b1;
    logic [7:0] req_n = 8'hFF;
    logic       ack = 1'b0;
    logic [2:0] code_n;
    logic       valid, gs_n, eo_n;
    int         n_vec = 0;
    int         n_err = 0;

    prio_enc_148 #(.DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .ei_n(ei_n), .req_n(req_n), .ack(ack),
        .code_n(code_n), .valid(valid), .gs_n(gs_n), .eo_n(eo_n)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [2:0] c);
        check({tag, ".valid"}, 8'(valid), 8'(v));
        check({tag, ".code_n"}, 8'(code_n), 8'(c));
    endtask

    initial begin
        step(2);
        chk_out("reset", 1'b0, 3'b111);
        check("reset.gs_n", 8'(gs_n), 8'd1);
        check("reset.eo_n", 8'(eo_n), 8'd1);
        rst = 1'b0;
`ifdef PRIO_ENC_DEBOUNCE_EN
        ei_n = 1'b0;
        req_n = 8'hFB;
        step(3);
        req_n = 8'hFF;
        step(8);
        chk_out("glitch3", 1'b0, 3'b111);
        check("glitch3.eo_n", 8'(eo_n), 8'd0);
        req_n = 8'hFB;
        step(6);
        check("deb6.gs_n", 8'(gs_n), 8'd0);
        step(2);
        chk_out("deb6", 1'b1, 3'b101);
`else
        ei_n = 1'b0;
        step(2);
        chk_out("idle_none", 1'b0, 3'b111);
        check("idle_none.gs_n", 8'(gs_n), 8'd1);
        check("idle_none.eo_n", 8'(eo_n), 8'd0);
        req_n = 8'b1101_0111;
        step(1);
        check("lat1.valid", 8'(valid), 8'd0);
        check("lat1.gs_n", 8'(gs_n), 8'd0);
        check("lat1.eo_n", 8'(eo_n), 8'd1);
        step(1);
        chk_out("cap5", 1'b1, 3'b010);
        req_n = 8'h7F;
        ei_n = 1'b1;
        step(2);
        chk_out("hold5", 1'b1, 3'b010);
        check("hold5.gs_n", 8'(gs_n), 8'd1);
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        chk_out("ack5", 1'b0, 3'b111);
        step(1);
        ei_n = 1'b0;
        step(1);
        check("idle_ei_wait.valid", 8'(valid), 8'd0);
        step(1);
        chk_out("cap7", 1'b1, 3'b000);
        ack = 1'b1;
        req_n = 8'hFE;
        step(1);
        ack = 1'b0;
        chk_out("ack7", 1'b0, 3'b111);
        step(1);
        check("rel7_idle.valid", 8'(valid), 8'd0);
        step(1);
        chk_out("cap0", 1'b1, 3'b111);
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        step(3);
        chk_out("rel0_stay", 1'b0, 3'b111);
        req_n = 8'hFF;
        step(2);
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        check("ack_idle.valid", 8'(valid), 8'd0);
        req_n = 8'hEF;
        step(2);
        chk_out("cap4", 1'b1, 3'b011);
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        step(1);
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        step(2);
        chk_out("rel4_stay", 1'b0, 3'b111);
        req_n = 8'h7F;
        step(3);
        chk_out("cap7b", 1'b1, 3'b000);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk_out("rst_hold", 1'b0, 3'b111);
        check("rst_hold.gs_n", 8'(gs_n), 8'd1);
        check("rst_hold.eo_n", 8'(eo_n), 8'd1);
        step(1);
        check("post_rst.valid", 8'(valid), 8'd0);
        step(1);
        chk_out("post_rst_cap", 1'b1, 3'b000);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
